mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter_if.sv | 45 ++++
 rtl/mem_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// +----------------------------------------------------------------------------+
// | mem_arbiter_if                                                             |
// | Request/grant bundle of the three requesters plus the memory-macro side.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              req_d,   req_f,   req_x;
    logic              we_d,    we_f,    we_x;
    logic [ADDR_W-1:0] addr_d,  addr_f,  addr_x;
    logic [DATA_W-1:0] wdata_d, wdata_f, wdata_x;
    logic              gnt_d,   gnt_f,   gnt_x;
    logic              done_d,  done_f,  done_x;
    logic [DATA_W-1:0] rdata;
    logic              busy;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter side.
    modport slave (
        input  req_d, req_f, req_x, we_d, we_f, we_x,
        input  addr_d, addr_f, addr_x, wdata_d, wdata_f, wdata_x,
        input  mem_rdata,
        output gnt_d, gnt_f, gnt_x, done_d, done_f, done_x,
        output rdata, busy, mem_en, mem_we, mem_addr, mem_wdata
    );

    // Requesters and memory side.
    modport master (
        output req_d, req_f, req_x, we_d, we_f, we_x,
        output addr_d, addr_f, addr_x, wdata_d, wdata_f, wdata_x,
        output mem_rdata,
        input  gnt_d, gnt_f, gnt_x, done_d, done_f, done_x,
        input  rdata, busy, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

`default_nettype wire

// File: rtl/mem_arbiter.sv
// +----------------------------------------------------------------------------+
// | mem_arbiter                                                                |
// | Shares one synchronous memory port between data, fetch and DMA requesters. |
// | Define MEM_ARB_RR_EN for round-robin arbitration (default: fixed D>F>X).   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module mem_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 1
) (
    input  wire           clk,
    input  wire           reset,
    mem_arbiter_if.slave  bus
);
    localparam int CNT_W = $clog2(MEM_LAT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        win_q, win_d;
    logic [2:0]        gnt_vec_q, gnt_vec_d;
    logic [2:0]        done_vec_q, done_vec_d;
    logic              busy_q, busy_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic [2:0]        req_vec;
    logic [2:0]        pick;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    assign req_vec = {bus.req_x, bus.req_f, bus.req_d};

`ifdef MEM_ARB_RR_EN
    // Index of the last winner: 0 = D, 1 = F, 2 = X.
    logic [1:0] last_q, last_d;

    always_comb begin
        pick = 3'b000;
        case (last_q)
            2'd0: begin
                if      (req_vec[1]) pick = 3'b010;
                else if (req_vec[2]) pick = 3'b100;
                else if (req_vec[0]) pick = 3'b001;
            end
            2'd1: begin
                if      (req_vec[2]) pick = 3'b100;
                else if (req_vec[0]) pick = 3'b001;
                else if (req_vec[1]) pick = 3'b010;
            end
            default: begin
                if      (req_vec[0]) pick = 3'b001;
                else if (req_vec[1]) pick = 3'b010;
                else if (req_vec[2]) pick = 3'b100;
            end
        endcase

        last_d = last_q;
        if (state_q == IDLE) begin
            if      (pick[0]) last_d = 2'd0;
            else if (pick[1]) last_d = 2'd1;
            else if (pick[2]) last_d = 2'd2;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) last_q <= 2'd2;
        else       last_q <= last_d;
    end
`else
    always_comb begin
        pick = 3'b000;
        if      (req_vec[0]) pick = 3'b001;
        else if (req_vec[1]) pick = 3'b010;
        else if (req_vec[2]) pick = 3'b100;
    end
`endif

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        case (pick)
            3'b001: begin
                sel_we    = bus.we_d;
                sel_addr  = bus.addr_d;
                sel_wdata = bus.wdata_d;
            end
            3'b010: begin
                sel_we    = bus.we_f;
                sel_addr  = bus.addr_f;
                sel_wdata = bus.wdata_f;
            end
            3'b100: begin
                sel_we    = bus.we_x;
                sel_addr  = bus.addr_x;
                sel_wdata = bus.wdata_x;
            end
            default: ;
        endcase
    end

    // The mem_* registers double as the latched request fields: they are
    // loaded at the sampling edge and only consumed during ACCESS.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        win_d       = win_q;
        gnt_vec_d   = 3'b000;
        done_vec_d  = 3'b000;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        rdata_d     = rdata_q;

        case (state_q)
            IDLE: begin
                if (|req_vec) begin
                    win_d       = pick;
                    gnt_vec_d   = pick;
                    mem_en_d    = 1'b1;
                    mem_we_d    = sel_we;
                    mem_addr_d  = sel_addr;
                    mem_wdata_d = sel_wdata;
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                if (mem_we_q) begin
                    done_vec_d = win_q;
                    state_d    = IDLE;
                end else begin
                    cnt_d   = CNT_W'(MEM_LAT - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    rdata_d    = bus.mem_rdata;
                    done_vec_d = win_q;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            win_q       <= 3'b000;
            gnt_vec_q   <= 3'b000;
            done_vec_q  <= 3'b000;
            busy_q      <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            win_q       <= win_d;
            gnt_vec_q   <= gnt_vec_d;
            done_vec_q  <= done_vec_d;
            busy_q      <= busy_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
        end
    end

    assign bus.gnt_d     = gnt_vec_q[0];
    assign bus.gnt_f     = gnt_vec_q[1];
    assign bus.gnt_x     = gnt_vec_q[2];
    assign bus.done_d    = done_vec_q[0];
    assign bus.done_f    = done_vec_q[1];
    assign bus.done_x    = done_vec_q[2];
    assign bus.busy      = busy_q;
    assign bus.rdata     = rdata_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// +----------------------------------------------------------------------------+
// | tb_mem_arbiter                                                             |
// | Two arbiters (MEM_LAT 1 and 3) checked against a timestamp-based model.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_mem_arbiter;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // Index 0: MEM_LAT = 1 arbiter, index 1: MEM_LAT = 3 arbiter.
    // Requester index within a vector: 0 = D, 1 = F, 2 = X.
    logic [1:0][2:0]       req;
    logic [1:0][2:0]       we;
    logic [1:0][2:0][15:0] addr;
    logic [1:0][2:0][15:0] wdata;
    logic [1:0][2:0]       gnt, done;
    logic [1:0]            busy, mem_en, mem_we;
    logic [1:0][15:0]      mem_addr, mem_wdata, rdata;

    int checks = 0;
    int passes = 0;

    function automatic logic [15:0] memf(input logic [15:0] a);
        return (a == 16'h0010) ? 16'hBEEF : (a ^ 16'h5A5A);
    endfunction

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    for (genvar k = 0; k < 2; k++) begin : g_dut
        localparam int LAT = (k == 0) ? 1 : 3;
        logic [15:0] pipe [3];

        mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

        assign bus.req_d   = req[k][0];
        assign bus.req_f   = req[k][1];
        assign bus.req_x   = req[k][2];
        assign bus.we_d    = we[k][0];
        assign bus.we_f    = we[k][1];
        assign bus.we_x    = we[k][2];
        assign bus.addr_d  = addr[k][0];
        assign bus.addr_f  = addr[k][1];
        assign bus.addr_x  = addr[k][2];
        assign bus.wdata_d = wdata[k][0];
        assign bus.wdata_f = wdata[k][1];
        assign bus.wdata_x = wdata[k][2];
        assign bus.mem_rdata = pipe[LAT-1];

        assign gnt[k]       = {bus.gnt_x, bus.gnt_f, bus.gnt_d};
        assign done[k]      = {bus.done_x, bus.done_f, bus.done_d};
        assign busy[k]      = bus.busy;
        assign mem_en[k]    = bus.mem_en;
        assign mem_we[k]    = bus.mem_we;
        assign mem_addr[k]  = bus.mem_addr;
        assign mem_wdata[k] = bus.mem_wdata;
        assign rdata[k]     = bus.rdata;

        // Memory with LAT-edge read pipeline; idle cycles push garbage.
        always @(posedge clk) begin
            pipe[0] <= bus.mem_en ? memf(bus.mem_addr) : 16'hDEAD;
            pipe[1] <= pipe[0];
            pipe[2] <= pipe[1];
        end

        mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(LAT)) u_dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus)
        );
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    endtask

    // ---------------- model: one transaction in flight, timed by edge index
    int               edge_n;
    bit               m_act   [2];
    int               m_dedge [2];
    int               m_win   [2];
    bit               m_we    [2];
    logic [15:0]      m_addr  [2];
`ifdef MEM_ARB_RR_EN
    int               m_last  [2];
`endif
    logic [1:0][2:0]  e_gnt, e_done;
    logic [1:0]       e_busy, e_en, e_we;
    logic [1:0][15:0] e_addr, e_wdata, e_rdata;

    function automatic int pick(input int k);
        int start;
`ifdef MEM_ARB_RR_EN
        start = m_last[k];
`else
        start = 2;
`endif
        for (int i = 1; i <= 3; i++) begin
            if (req[k][(start + i) % 3]) return (start + i) % 3;
        end
        return 0;
    endfunction

    task automatic model_clear();
        edge_n = 0;
        for (int k = 0; k < 2; k++) begin
            m_act[k] = 1'b0;
`ifdef MEM_ARB_RR_EN
            m_last[k] = 2;
`endif
            e_gnt[k] = '0; e_done[k] = '0; e_busy[k] = 1'b0;
            e_en[k] = 1'b0; e_we[k] = 1'b0;
            e_addr[k] = '0; e_wdata[k] = '0; e_rdata[k] = '0;
        end
    endtask

    task automatic model_step(input int k);
        int w;
        e_gnt[k] = '0; e_done[k] = '0; e_en[k] = 1'b0; e_we[k] = 1'b0;
        e_addr[k] = '0; e_wdata[k] = '0;
        if (m_act[k] && edge_n == m_dedge[k]) begin
            e_done[k] = 3'(1 << m_win[k]);
            if (!m_we[k]) e_rdata[k] = memf(m_addr[k]);
            m_act[k] = 1'b0;
        end else if (!m_act[k] && req[k] != 3'b000) begin
            w          = pick(k);
            m_act[k]   = 1'b1;
            m_win[k]   = w;
            m_we[k]    = we[k][w];
            m_addr[k]  = addr[k][w];
            m_dedge[k] = edge_n + (m_we[k] ? 1 : 1 + lat_of(k));
`ifdef MEM_ARB_RR_EN
            m_last[k]  = w;
`endif
            e_gnt[k]   = 3'(1 << w);
            e_en[k]    = 1'b1;
            e_we[k]    = m_we[k];
            e_addr[k]  = addr[k][w];
            e_wdata[k] = wdata[k][w];
        end
        e_busy[k] = m_act[k];
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) model_clear();
            else begin
                edge_n++;
                for (int k = 0; k < 2; k++) model_step(k);
            end
        end
    end

    // ---------------- per-cycle compare against the model
    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("gnt[%0d]", k),       {13'd0, gnt[k]},  {13'd0, e_gnt[k]});
                chk($sformatf("done[%0d]", k),      {13'd0, done[k]}, {13'd0, e_done[k]});
                chk($sformatf("busy[%0d]", k),      {15'd0, busy[k]},   {15'd0, e_busy[k]});
                chk($sformatf("mem_en[%0d]", k),    {15'd0, mem_en[k]}, {15'd0, e_en[k]});
                chk($sformatf("mem_we[%0d]", k),    {15'd0, mem_we[k]}, {15'd0, e_we[k]});
                chk($sformatf("mem_addr[%0d]", k),  mem_addr[k],  e_addr[k]);
                chk($sformatf("mem_wdata[%0d]", k), mem_wdata[k], e_wdata[k]);
                chk($sformatf("rdata[%0d]", k),     rdata[k],     e_rdata[k]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- directed stimulus with literal expectations
    int order[$];

    initial begin
        req = '0; we = '0; addr = '0; wdata = '0;
        cyc(3);
        chk("reset_gnt",   {13'd0, gnt[0]}, 16'h0000);
        chk("reset_busy",  {15'd0, busy[0]}, 16'h0000);
        chk("reset_rdata", rdata[0], 16'h0000);
        reset = 1'b0;
        cyc(2);

        // Single fetch read, MEM_LAT = 1.
        req[0] = 3'b010; we[0] = 3'b000; addr[0][1] = 16'h0010;
        cyc(1);
        chk("t1_gnt_f",   {13'd0, gnt[0]}, 16'h0002);
        chk("t1_addr",    mem_addr[0], 16'h0010);
        chk("t1_we",      {15'd0, mem_we[0]}, 16'h0000);
        req[0] = 3'b000;
        cyc(1);
        chk("t1_wait",    {13'd0, done[0]}, 16'h0000);
        cyc(1);
        chk("t1_done_f",  {13'd0, done[0]}, 16'h0002);
        chk("t1_rdata",   rdata[0], 16'hBEEF);
        cyc(1);
        chk("t1_busy",    {15'd0, busy[0]}, 16'h0000);

        // D write and F read requested together.
        cyc(1);
        req[0] = 3'b011; we[0] = 3'b001;
        addr[0][0] = 16'h0200; wdata[0][0] = 16'h1234; addr[0][1] = 16'h0004;
        cyc(1);
        chk("t2_gnt_d",   {13'd0, gnt[0]}, 16'h0001);
        chk("t2_wdata",   mem_wdata[0], 16'h1234);
        req[0] = 3'b010;
        cyc(1);
        chk("t2_done_d",  {13'd0, done[0]}, 16'h0001);
        cyc(1);
        chk("t2_gnt_f",   {13'd0, gnt[0]}, 16'h0002);
        chk("t2_addr_f",  mem_addr[0], 16'h0004);
        req[0] = 3'b000;
        cyc(2);
        chk("t2_done_f",  {13'd0, done[0]}, 16'h0002);
        chk("t2_rdata",   rdata[0], 16'h5A5E);

        // All three held: pointer reset to X first.
        cyc(1);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        we[0] = 3'b000;
        addr[0][0] = 16'h0100; addr[0][1] = 16'h0101; addr[0][2] = 16'h0102;
        req[0] = 3'b111;
        for (int i = 0; i < 18; i++) begin
            cyc(1);
            if (gnt[0][0]) order.push_back(0);
            else if (gnt[0][1]) order.push_back(1);
            else if (gnt[0][2]) order.push_back(2);
        end
        req[0] = 3'b000;
        chk("t3_ngrants", 16'(order.size()), 16'd6);
        for (int i = 0; i < 6; i++) begin
            int got;
            got = (i < order.size()) ? order[i] : 7;
`ifdef MEM_ARB_RR_EN
            chk($sformatf("t3_order%0d", i), 16'(got), 16'(i % 3));
`else
            chk($sformatf("t3_order%0d", i), 16'(got), 16'd0);
`endif
        end
        cyc(6);

        // Reset during the WAIT of a D read.
        req[0] = 3'b001; addr[0][0] = 16'h0100;
        cyc(1);
        chk("t4_gnt_d",   {13'd0, gnt[0]}, 16'h0001);
        req[0] = 3'b000;
        cyc(1);
        chk("t4_inwait",  {15'd0, busy[0]}, 16'h0001);
        #1 reset = 1'b1;
        #1;
        chk("t4_rst_busy",  {15'd0, busy[0]}, 16'h0000);
        chk("t4_rst_rdata", rdata[0], 16'h0000);
        cyc(1);
        reset = 1'b0;
        cyc(1);
        chk("t4_no_done", {13'd0, done[0]}, 16'h0000);
        req[0] = 3'b010; addr[0][1] = 16'h0020;
        cyc(1);
        chk("t4_gnt_f",   {13'd0, gnt[0]}, 16'h0002);
        req[0] = 3'b000;
        cyc(2);
        chk("t4_done_f",  {13'd0, done[0]}, 16'h0002);
        chk("t4_rdata",   rdata[0], 16'h5A7A);

        // Back-to-back D writes.
        cyc(1);
        req[0] = 3'b001; we[0] = 3'b001; addr[0][0] = 16'h0200; wdata[0][0] = 16'h1111;
        cyc(1);
        chk("t5_gnt1",    {13'd0, gnt[0]}, 16'h0001);
        addr[0][0] = 16'h0300; wdata[0][0] = 16'h2222;
        cyc(1);
        chk("t5_done1",   {13'd0, done[0]}, 16'h0001);
        cyc(1);
        chk("t5_gnt2",    {13'd0, gnt[0]}, 16'h0001);
        chk("t5_addr2",   mem_addr[0], 16'h0300);
        chk("t5_wdata2",  mem_wdata[0], 16'h2222);
        req[0] = 3'b000; we[0] = 3'b000;
        cyc(3);

        // MEM_LAT = 3 read from X; address changed during WAIT.
        req[1] = 3'b100; we[1] = 3'b000; addr[1][2] = 16'hFFFF;
        cyc(1);
        chk("t6_gnt_x",   {13'd0, gnt[1]}, 16'h0004);
        chk("t6_addr",    mem_addr[1], 16'hFFFF);
        req[1] = 3'b000;
        cyc(1);
        chk("t6_en_off",  {15'd0, mem_en[1]}, 16'h0000);
        addr[1][2] = 16'h0000;
        cyc(2);
        chk("t6_early",   {13'd0, done[1]}, 16'h0000);
        cyc(1);
        chk("t6_done_x",  {13'd0, done[1]}, 16'h0004);
        chk("t6_rdata",   rdata[1], 16'hA5A5);
        cyc(3);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

`default_nettype wire
